// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter driving a single-port SRAM with registered pins
// SRAM_ARB_FIXED_PRIO_EN: port A always wins simultaneous requests; no round-robin pointer.
module sram_arbiter #(
  parameter int AddressSize  = 18,
  parameter int WordSize     = 8,
  parameter int AccessCycles = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ReqA,
  input  logic                   ReqB,
  input  logic                   WeA,
  input  logic                   WeB,
  input  logic [AddressSize-1:0] AddrA,
  input  logic [AddressSize-1:0] AddrB,
  input  logic [WordSize-1:0]    WDataA,
  input  logic [WordSize-1:0]    WDataB,
  output logic                   AckA,
  output logic                   AckB,
  output logic [WordSize-1:0]    RDataA,
  output logic [WordSize-1:0]    RDataB,
  output logic [AddressSize-1:0] SramAddress,
  output logic [WordSize-1:0]    SramInData,
  input  logic [WordSize-1:0]    SramOutData,
  output logic                   SramBCE,
  output logic                   SramBWE,
  output logic                   Busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  localparam logic [3:0] LastCount = 4'(AccessCycles - 1);

  state_t     state, next_state;
  logic [3:0] count;
  logic       grant_b;
  logic       op_we;
  logic       any_req;
  logic       win_b;
  logic       last_access;

  assign any_req     = ReqA | ReqB;
  assign last_access = (state == ACCESS) && (count == LastCount);

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign win_b = ReqB & ~ReqA;
`else
  // favour_b is set when A was granted last, so B wins the next tie
  logic favour_b;
  assign win_b = ReqB & (~ReqA | favour_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      favour_b <= 1'b0;
    end else if (state == IDLE && any_req) begin
      favour_b <= ~win_b;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (last_access) next_state = HOLD;
      HOLD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Every pin is registered; values are loaded on the edge that enters the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= 4'd0;
      grant_b     <= 1'b0;
      op_we       <= 1'b0;
      AckA        <= 1'b0;
      AckB        <= 1'b0;
      RDataA      <= '0;
      RDataB      <= '0;
      SramAddress <= '0;
      SramInData  <= '0;
      SramBCE     <= 1'b1;
      SramBWE     <= 1'b1;
      Busy        <= 1'b0;
    end else begin
      AckA <= 1'b0;
      AckB <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_b     <= win_b;
            op_we       <= win_b ? WeB : WeA;
            SramAddress <= win_b ? AddrB : AddrA;
            SramInData  <= win_b ? WDataB : WDataA;
            Busy        <= 1'b1;
          end
        end
        SETUP: begin
          count   <= 4'd0;
          SramBCE <= 1'b0;
          SramBWE <= ~op_we;
        end
        ACCESS: begin
          count <= count + 4'd1;
          if (last_access) begin
            SramBCE <= 1'b1;
            SramBWE <= 1'b1;
            AckA    <= ~grant_b;
            AckB    <= grant_b;
            if (!op_we) begin
              if (grant_b) RDataB <= SramOutData;
              else         RDataA <= SramOutData;
            end
          end
        end
        HOLD: begin
          Busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - randomized bench for sram_arbiter with a cycle-level reference model
// Model tracks each access as a phase index (0 idle, 1 setup, 2..AC+1 access, AC+2 hold).
module tb_sram_arbiter;
  localparam int AC = 2;
  localparam int HT = AC + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [17:0] addr [2];
  logic [7:0]  wdata [2];
  logic        AckA, AckB, SramBCE, SramBWE, Busy;
  logic [7:0]  RDataA, RDataB, SramInData, sram_out;
  logic [17:0] SramAddress;

  int n_tests = 0;
  int n_fail  = 0;

  sram_arbiter #(.AddressSize(18), .WordSize(8), .AccessCycles(AC)) dut (
    .clk(clk), .rst(rst),
    .ReqA(req[0]), .ReqB(req[1]), .WeA(we[0]), .WeB(we[1]),
    .AddrA(addr[0]), .AddrB(addr[1]), .WDataA(wdata[0]), .WDataB(wdata[1]),
    .AckA(AckA), .AckB(AckB), .RDataA(RDataA), .RDataB(RDataB),
    .SramAddress(SramAddress), .SramInData(SramInData), .SramOutData(sram_out),
    .SramBCE(SramBCE), .SramBWE(SramBWE), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM behaviour: unwritten words read as a[7:0]^0x3C; a write commits when the enable pulse ends cleanly
  logic [7:0]  mem [logic [17:0]];
  logic [7:0]  ref_mem [logic [17:0]];
  logic        pend = 1'b0;
  logic [17:0] pa;
  logic [7:0]  pd;

  function automatic logic [7:0] def_val(input logic [17:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  always @(negedge clk) begin
    if (rst) pend = 1'b0;
    else if (!SramBCE && !SramBWE) begin pend = 1'b1; pa = SramAddress; pd = SramInData; end
    else if (pend && SramBCE) begin mem[pa] = pd; pend = 1'b0; end
    sram_out = mem.exists(SramAddress) ? mem[SramAddress] : def_val(SramAddress);
  end

  function automatic logic [7:0] ref_rd(input logic [17:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : def_val(a);
  endfunction

  int          m_t = 0;
  int          m_win = 0;
  int          m_last = 1;
  logic        m_we;
  logic [17:0] m_addr;
  logic [7:0]  m_wdata;
  logic [7:0]  m_rd [2];
  bit          done [2];
  bit          in_access;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_bce", SramBCE, 1);
      chk("rst_bwe", SramBWE, 1);
      chk("rst_busy", Busy, 0);
      chk("rst_ack", {AckA, AckB}, 0);
      chk("rst_rdata", {RDataA, RDataB}, 0);
      chk("rst_addr", SramAddress, 0);
      m_t = 0; m_last = 1; m_rd[0] = 8'h00; m_rd[1] = 8'h00; done[0] = 0; done[1] = 0;
    end else begin
      in_access = (m_t >= 2) && (m_t <= AC + 1);
      chk("bce", SramBCE, !in_access);
      chk("bwe", SramBWE, !(in_access && m_we));
      chk("busy", Busy, m_t != 0);
      chk("ack_a", AckA, (m_t == HT) && (m_win == 0));
      chk("ack_b", AckB, (m_t == HT) && (m_win == 1));
      chk("rdata_a", RDataA, m_rd[0]);
      chk("rdata_b", RDataB, m_rd[1]);
      if (m_t != 0) begin
        chk("sram_addr", SramAddress, m_addr);
        chk("sram_wdata", SramInData, m_wdata);
      end
      if (m_t == 0) begin
        if (req[0] || req[1]) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
          m_win = req[0] ? 0 : 1;
`else
          m_win = (req[0] && req[1]) ? 1 - m_last : (req[0] ? 0 : 1);
`endif
          m_last = m_win; m_we = we[m_win]; m_addr = addr[m_win]; m_wdata = wdata[m_win];
          m_t = 1;
        end
      end else if (m_t == AC + 1) begin
        if (m_we) ref_mem[m_addr] = m_wdata;
        else      m_rd[m_win] = ref_rd(m_addr);
        m_t = HT;
      end else if (m_t == HT) begin
        done[m_win] = 1; m_t = 0;
      end else begin
        m_t++;
      end
    end
  end

  task automatic run_one(input int p, input logic w, input logic [17:0] a, input logic [7:0] d,
                         input logic [17:0] a_mut, output int lat, output int bcel, output int bwel,
                         output logic [7:0] rd, output logic addr_ok);
    @(posedge clk); #1;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    lat = -1; bcel = 0; bwel = 0; rd = 8'h00; addr_ok = 1'b1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (k >= 1 && SramAddress !== a) addr_ok = 1'b0;
      if (!SramBCE) bcel++;
      if (!SramBCE && !SramBWE) bwel++;
      if (p == 0 ? AckA : AckB) begin lat = k; rd = (p == 0) ? RDataA : RDataB; end
      if (k == 2 && a_mut != a) begin #1; addr[p] = a_mut; end
    end
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  task automatic new_op(input int p);
    we[p] = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       addr[p] = 18'h3FFFF;
      1:       addr[p] = 18'h00000;
      default: addr[p] = 18'($urandom_range(0, 7));
    endcase
    wdata[p] = 8'($urandom);
  endtask

  int          lat, bcel, bwel, n, last_k;
  logic [7:0]  rd;
  logic        addr_ok, seen, gap_next;
  int          g [4];

  initial begin
    rst = 1'b1; req = 2'b00; we = 2'b00;
    addr[0] = 18'h0; addr[1] = 18'h0; wdata[0] = 8'h0; wdata[1] = 8'h0;
    #3;
    chk("init_bce_bwe", {SramBCE, SramBWE}, 2'b11);
    chk("init_ack_busy", {AckA, AckB, Busy}, 3'b000);
    chk("init_addr_data", {SramAddress, SramInData}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_one(0, 1'b1, 18'h00010, 8'h5A, 18'h00010, lat, bcel, bwel, rd, addr_ok);
    chk("wr_latency", lat, 4);
    chk("wr_bce_low_cycles", bcel, 2);
    chk("wr_bwe_low_cycles", bwel, 2);

    run_one(0, 1'b1, 18'h3FFFF, 8'h5A, 18'h3FFFF, lat, bcel, bwel, rd, addr_ok);
    run_one(1, 1'b0, 18'h3FFFF, 8'h00, 18'h3FFFF, lat, bcel, bwel, rd, addr_ok);
    chk("readback_rdata_b", rd, 8'h5A);
    chk("readback_addr_held", addr_ok, 1);
    chk("rd_bwe_low_cycles", bwel, 0);

    run_one(0, 1'b0, 18'h00001, 8'h00, 18'h00002, lat, bcel, bwel, rd, addr_ok);
    chk("latch_addr_held", addr_ok, 1);
    chk("latch_rdata_a", rd, 8'h3D);

    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 18'h00020; wdata[0] = 8'hC3;
    repeat (3) @(negedge clk);
    chk("abort_in_access", SramBCE, 0);
    #2 rst = 1'b1;
    #1;
    chk("abort_bce", SramBCE, 1);
    chk("abort_bwe", SramBWE, 1);
    chk("abort_busy", Busy, 0);
    req[0] = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (AckA || AckB) seen = 1'b1; end
    chk("abort_no_ack", seen, 0);
    @(posedge clk); #1 rst = 1'b0;
    run_one(1, 1'b0, 18'h00020, 8'h00, 18'h00020, lat, bcel, bwel, rd, addr_ok);
    chk("abort_old_data", rd, 8'h1C);

    @(posedge clk); #1;
    req = 2'b11; we = 2'b00; addr[0] = 18'h5; addr[1] = 18'h6;
    n = 0; last_k = -1; gap_next = 1'b0;
    for (int i = 0; i < 4; i++) g[i] = -1;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clk);
      if (gap_next) begin chk("gap_bce", SramBCE, 1); gap_next = 1'b0; end
      if (AckA || AckB) begin
        g[n] = AckB ? 1 : 0;
        if (n > 0) chk("b2b_spacing", k - last_k, AC + 3);
        last_k = k; n++; gap_next = 1'b1;
      end
    end
    @(posedge clk); #1 req = 2'b00;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) chk("contention_grant", g[i], 0);
`else
    for (int i = 0; i < 4; i++) chk("contention_grant", g[i], i % 2);
`endif

    repeat (2) @(posedge clk);
    done[0] = 0; done[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (done[p]) begin
          done[p] = 0;
          if (c >= 2800 || $urandom_range(0, 1) == 0) req[p] = 1'b0;
          else new_op(p);
        end else if (!req[p]) begin
          if (c < 2800 && $urandom_range(0, 2) == 0) begin new_op(p); req[p] = 1'b1; end
        end else if (m_t != 0 && m_win == p && $urandom_range(0, 1) == 1) begin
          new_op(p);
        end
      end
    end
    req = 2'b00;
    repeat (10) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
